// File: rtl/cory_rr_merge2.sv
// rtl/cory_rr_merge2.sv - two-input round-robin merge with 2-entry registered output buffer
// Define CORY_RR_MERGE2_LOCK_EN to hold the grant on one input until its last-of-packet beat.
module cory_rr_merge2 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_a0_v,
  input  logic [N-1:0] i_a0_d,
  input  logic         i_a0_l,
  output logic         o_a0_r,
  input  logic         i_a1_v,
  input  logic [N-1:0] i_a1_d,
  input  logic         i_a1_l,
  output logic         o_a1_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic         o_z_l,
  output logic         o_z_s,
  input  logic         i_z_r
);

  localparam int W = N + 2;

  // Buffer entries hold {data, last, source}; ent0 is always the head.
  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pri_q, pri_d;
  logic         space, gnt_v, gnt, push, pop;
  logic [W-1:0] in_ent;
`ifdef CORY_RR_MERGE2_LOCK_EN
  logic         lock_q, lock_d, lsrc_q, lsrc_d;
`endif

  always_comb begin
    space = (cnt_q != 2'd2);
    gnt_v = i_a0_v | i_a1_v;
    gnt   = (i_a0_v && i_a1_v) ? pri_q : i_a1_v;
`ifdef CORY_RR_MERGE2_LOCK_EN
    if (lock_q) begin
      gnt   = lsrc_q;
      gnt_v = lsrc_q ? i_a1_v : i_a0_v;
    end
`endif
    // Readies come only from registered occupancy, never from i_z_r.
    o_a0_r = reset_n & space & gnt_v & ~gnt;
    o_a1_r = reset_n & space & gnt_v & gnt;
    push   = (o_a0_r & i_a0_v) | (o_a1_r & i_a1_v);
    pop    = (cnt_q != 2'd0) & i_z_r;
    in_ent = gnt ? {i_a1_d, i_a1_l, 1'b1} : {i_a0_d, i_a0_l, 1'b0};
  end

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    pri_d  = pri_q;
    case (cnt_q)
      2'd0: if (push) ent0_d = in_ent;
      2'd1: begin
        if (push && pop) ent0_d = in_ent;
        else if (push)   ent1_d = in_ent;
      end
      default: if (pop) ent0_d = ent1_q;
    endcase
`ifdef CORY_RR_MERGE2_LOCK_EN
    lock_d = lock_q;
    lsrc_d = lsrc_q;
    if (push) begin
      lock_d = ~in_ent[1];
      lsrc_d = gnt;
      if (in_ent[1]) pri_d = ~gnt;
    end
`else
    if (push) pri_d = ~gnt;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
      pri_q  <= 1'b0;
`ifdef CORY_RR_MERGE2_LOCK_EN
      lock_q <= 1'b0;
      lsrc_q <= 1'b0;
`endif
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
      pri_q  <= pri_d;
`ifdef CORY_RR_MERGE2_LOCK_EN
      lock_q <= lock_d;
      lsrc_q <= lsrc_d;
`endif
    end
  end

  assign o_z_v = (cnt_q != 2'd0);
  assign o_z_d = ent0_q[W-1:2];
  assign o_z_l = ent0_q[1];
  assign o_z_s = ent0_q[0];

endmodule

// File: doc/cory_rr_merge2.md
# cory_rr_merge2

Two-input round-robin merge stage with a registered output. It accepts two valid/ready streams, grants one beat per cycle using fair arbitration, and emits the merged beat tagged with its source index (`o_z_s`). It is the counterpart of the 2-way demux: it recombines split streams, such as responses returning from two lanes, and the `o_z_s` tag can drive a downstream demux select stream.

## Interface
Parameters:
- `N`, 8, data width of each beat

Ports:
- `clk`  input  1  clock, all state on rising edge
- `reset_n`  input  1  reset, asynchronous assert, active-low
- `i_a0_v`  input  1  input 0 valid
- `i_a0_d`  input  N  input 0 data
- `i_a0_l`  input  1  input 0 last-of-packet flag
- `o_a0_r`  output  1  input 0 ready
- `i_a1_v`  input  1  input 1 valid
- `i_a1_d`  input  N  input 1 data
- `i_a1_l`  input  1  input 1 last-of-packet flag
- `o_a1_r`  output  1  input 1 ready
- `o_z_v`  output  1  merged output valid
- `o_z_d`  output  N  merged output data
- `o_z_l`  output  1  merged last flag, copied from the granted input
- `o_z_s`  output  1  source index of the output beat (0 or 1)
- `i_z_r`  input  1  output ready

## Operation
- Handshake on every port: a transfer occurs in a cycle where v && r are both high. `v` must not drop before its transfer; `d`, `l` and `s` must stay stable while `v` is high.
- Output buffer: a 2-entry FIFO of {d, l, s}, with occupancy `cnt` in 0..2. `o_z_v` = (`cnt` != 0). The output fields come from the head entry.
- Space: `space` = (`cnt` != 2). `space` is registered state, so the input readies never depend on `i_z_r`.
- Round-robin pointer `pri` (1 bit) names the input that wins a tie.
- Grant, combinational:
  - Only a0 valid: `gnt`=0.
  - Only a1 valid: `gnt`=1.
  - Both valid: `gnt`=`pri`.
  - Neither valid: no grant.
- Readies: `o_a0_r` = `space` && granted 0. `o_a1_r` = `space` && granted 1. At most one ready is high in any cycle. A ready may rise only in response to its own valid.
- On a transfer from input k:
  - Push {`i_ak_d`, `i_ak_l`, k}.
  - Set `pri` to !k (the loser of the cycle gets priority next).
- Push and pop in the same cycle: `cnt` is unchanged and the order is preserved.
- No push while full. Pop only when `cnt` != 0.

## Timing
- Latency: a beat accepted in cycle t appears on `o_z_*` in cycle t+1.
- Throughput: 1 beat per cycle sustained while `i_z_r` is held high.
- With `i_z_r` low: two more beats are accepted, then both readies go low. When `i_z_r` rises, `cnt` falls to 1 and the readies return the following cycle.
- Reset values while `reset_n` is low:
  - `cnt`=0, `pri`=0.
  - `o_z_v`=0, `o_z_d`=0, `o_z_l`=0, `o_z_s`=0.
  - `o_a0_r`=`o_a1_r`=0; the readies are gated with `reset_n`.
- Reset mid-operation: the FIFO contents are discarded, and any in-progress packet lock is cleared.
- Sequence order at the output equals acceptance order. The merge never reorders beats or creates duplicates.

## Configuration
- `CORY_RR_MERGE2_LOCK_EN` defined, packet lock enabled:
  - After a transfer from input k with `i_ak_l`=0, the grant is locked to k. The other input is not granted even if it has priority.
  - The lock releases on the transfer of k's beat with `l`=1.
  - `pri` updates only on a beat with `l`=1.
- Macro not defined:
  - The `l` flags are carried through to `o_z_l` only.
  - Arbitration is per beat, exactly as described in Operation.
- The port list is identical in both builds.

## Test plan
- Single input: a0 sends 0x11, 0x22, 0x33 back-to-back with `i_z_r`=1 and a1 idle -> `o_z_d` = 0x11, 0x22, 0x33 in cycles t+1..t+3, with `o_z_s`=0.
- Contention after reset: both inputs valid continuously (a0 sends 0xA0.., a1 sends 0xB0..), `i_z_r`=1 -> output sources alternate 0,1,0,1 starting with 0, and 1 beat is delivered per cycle.
- Backpressure: `i_z_r`=0 with a0 streaming -> exactly 2 beats are accepted and then `o_a0_r`=0. Raise `i_z_r` -> the held beats drain in order with no loss.
- Lock (macro defined): a0 sends a 3-beat packet (`l`=0,0,1) while a1 is valid with `pri`=1 -> a1 wins the first beat. A packet started later on a0 sends all 3 beats contiguously with a1 excluded, and a1 is granted next.
- Reset mid-stream: assert `reset_n`=0 with `cnt`=2 -> `o_z_v`=0 and both readies 0 immediately. After release, the first beat accepted from a1 appears with `o_z_s`=1 and no stale data.
- Scoreboard random run: 10k cycles with random valids and `i_z_r` -> output beats match per-source order, there is no starvation, and no more than 1 ready is ever high.
